// File: rtl/light_sequencer_pkg.sv
// light_sequencer_pkg: shared FSM state encoding and default data width
package light_sequencer_pkg;
  localparam int DW_DEF = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RD,
    ST_FILT,
    ST_WAIT_WRAP
  } state_t;
endpackage

// File: rtl/light_tick_gen.sv
// light_tick_gen: sample period counter, parked at 0 and silent while disabled
module light_tick_gen #(
  parameter int SAMPLE_PERIOD = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // wrap after the last count, hold at 0 while disabled
  always_comb cnt_d = (!en_i || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  // period counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tick_o = en_i && cnt_q == LAST;
endmodule

// File: rtl/light_sequencer.sv
// light_sequencer: sample scheduler, sensor read, filter wait and wrap-aligned duty commit
module light_sequencer
  import light_sequencer_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int RD_TIMEOUT    = 4096,
  parameter int FILTER_LAT    = 2,
  parameter int DW            = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          rd_req,
  input  logic          rd_done,
  input  logic [DW-1:0] rd_data,
  output logic          flt_valid,
  output logic [DW-1:0] flt_data,
  input  logic [DW-1:0] col_r,
  input  logic [DW-1:0] col_g,
  input  logic [DW-1:0] col_b,
  input  logic          pwm_wrap,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic          upd,
  input  logic          err_clr,
  output logic          err_timeout,
  output logic          overrun,
  output logic [15:0]   sample_cnt
);
  localparam int TW = $clog2(RD_TIMEOUT);
  localparam int LW = $clog2(FILTER_LAT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(FILTER_LAT);
  state_t        state_q;
  logic          tick;
  logic [TW-1:0] tmo_q;
  logic [LW-1:0] lat_q;
  logic [DW-1:0] sh_r_q, sh_g_q, sh_b_q;
  logic [DW-1:0] flt_data_q, duty_r_q, duty_g_q, duty_b_q;
  logic          rd_req_q, flt_valid_q, upd_q, err_q, ovr_q;
  logic [15:0]   cnt_q;
  light_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .tick_o(tick)
  );
  // sequencer FSM; flag sets are placed after the clear so a same-cycle set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      lat_q       <= '0;
      sh_r_q      <= '0;
      sh_g_q      <= '0;
      sh_b_q      <= '0;
      flt_data_q  <= '0;
      duty_r_q    <= '0;
      duty_g_q    <= '0;
      duty_b_q    <= '0;
      rd_req_q    <= 1'b0;
      flt_valid_q <= 1'b0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rd_req_q    <= 1'b0;
      flt_valid_q <= 1'b0;
      upd_q       <= 1'b0;
      if (err_clr) begin
        err_q <= 1'b0;
        ovr_q <= 1'b0;
      end
      if (tick && state_q != ST_IDLE) ovr_q <= 1'b1;
      case (state_q)
        ST_IDLE: if (tick) begin
          state_q  <= ST_REQ;
          rd_req_q <= 1'b1;
        end
        ST_REQ: begin
          state_q <= ST_WAIT_RD;
          tmo_q   <= '0;
        end
        ST_WAIT_RD: if (rd_done) begin
          flt_data_q  <= rd_data;
          flt_valid_q <= 1'b1;
          lat_q       <= '0;
          state_q     <= ST_FILT;
        end else if (tmo_q == TMO_LAST) begin
          err_q   <= 1'b1;
          state_q <= ST_IDLE;
        end else tmo_q <= tmo_q + 1'b1;
        ST_FILT: if (lat_q == LAT_LAST) begin
          sh_r_q  <= col_r;
          sh_g_q  <= col_g;
          sh_b_q  <= col_b;
          state_q <= ST_WAIT_WRAP;
        end else lat_q <= lat_q + 1'b1;
        ST_WAIT_WRAP: if (pwm_wrap) begin
          duty_r_q <= sh_r_q;
          duty_g_q <= sh_g_q;
          duty_b_q <= sh_b_q;
          upd_q    <= 1'b1;
          cnt_q    <= cnt_q + 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign rd_req      = rd_req_q;
  assign flt_valid   = flt_valid_q;
  assign flt_data    = flt_data_q;
  assign duty_r      = duty_r_q;
  assign duty_g      = duty_g_q;
  assign duty_b      = duty_b_q;
  assign upd         = upd_q;
  assign err_timeout = err_q;
  assign overrun     = ovr_q;
  assign sample_cnt  = cnt_q;
endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer: directed scenarios plus randomized trials against an edge-arithmetic model
module tb_light_sequencer;
  localparam int DW = 8;
  localparam int SP = 16;
  localparam int RT = 8;
  localparam int FL = 2;
  logic clk = 1'b0;
  logic rst, en, rd_done, pwm_wrap, err_clr;
  logic [DW-1:0] rd_data, col_r, col_g, col_b;
  logic rd_req, flt_valid, upd, err_timeout, overrun;
  logic [DW-1:0] flt_data, duty_r, duty_g, duty_b;
  logic [15:0] sample_cnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  light_sequencer #(.SAMPLE_PERIOD(SP), .RD_TIMEOUT(RT), .FILTER_LAT(FL), .DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .rd_req(rd_req), .rd_done(rd_done), .rd_data(rd_data),
    .flt_valid(flt_valid), .flt_data(flt_data), .col_r(col_r), .col_g(col_g), .col_b(col_b),
    .pwm_wrap(pwm_wrap), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .upd(upd),
    .err_clr(err_clr), .err_timeout(err_timeout), .overrun(overrun), .sample_cnt(sample_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_duty(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    chk({tag, "_r"}, duty_r, r);
    chk({tag, "_g"}, duty_g, g);
    chk({tag, "_b"}, duty_b, b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic set_col(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    col_r = r;
    col_g = g;
    col_b = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    rd_done = 1'b0;
    pwm_wrap = 1'b0;
    err_clr = 1'b0;
    rd_data = '0;
    set_col(8'h00, 8'h00, 8'h00);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input int lim, input string tag);
    int i;
    i = 0;
    while (rd_req !== 1'b1 && i < lim) begin
      step();
      i++;
    end
    chk(tag, rd_req, 1);
  endtask

  // one randomized read/commit; every expectation is an edge index measured from the rd_req cycle
  task automatic trial(input int t);
    int k, w, wrap_e;
    bit ok, busy;
    logic [7:0] d, cr, cg, cb;
    k = $urandom_range(1, 10);
    w = $urandom_range(1, 8);
    d = 8'($urandom);
    cr = 8'($urandom);
    cg = 8'($urandom);
    cb = 8'($urandom);
    ok = (k <= RT);
    wrap_e = 1 + k + 1 + FL + w;
    busy = ok && (wrap_e >= SP);
    do_reset();
    set_col(cr, cg, cb);
    en = 1'b1;
    rd_done = $urandom_range(0, 1);
    rd_data = 8'($urandom);
    wait_req(2 * SP, "rnd_req");
    rd_done = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      rd_done = (e == k + 1);
      rd_data = rd_done ? d : 8'($urandom);
      pwm_wrap = ok ? (e == wrap_e || (e <= k + 2 + FL && $urandom_range(0, 1) == 1)) : 1'($urandom_range(0, 1));
      step();
      chk("rnd_fv", flt_valid, ok && e == k + 1);
      if (ok && e == k + 1) chk("rnd_fd", flt_data, d);
      chk("rnd_req_e", rd_req, e == SP && !busy);
      chk("rnd_upd", upd, ok && e == wrap_e);
      chk("rnd_cnt", sample_cnt, (ok && e >= wrap_e) ? 1 : 0);
      if (ok && e >= wrap_e) chk_duty("rnd_duty", cr, cg, cb);
      else chk_duty("rnd_duty0", 0, 0, 0);
      chk("rnd_err", err_timeout, !ok && e >= RT + 1);
      chk("rnd_ovr", overrun, busy && e >= SP);
    end
    rd_done = 1'b0;
    pwm_wrap = 1'b0;
    if (t < 0) $display("unused");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit fv_seen;
    // reset state
    do_reset();
    chk("rst_req", rd_req, 0);
    chk("rst_fv", flt_valid, 0);
    chk("rst_fd", flt_data, 0);
    chk_duty("rst_duty", 0, 0, 0);
    chk("rst_upd", upd, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_ovr", overrun, 0);
    // nominal: read three cycles after rd_req, colour sampled exactly at the latch edge
    set_col(8'h77, 8'h77, 8'h77);
    en = 1'b1;
    wait_req(2 * SP + 4, "nom_req");
    step();
    chk("nom_req_pulse", rd_req, 0);
    step();
    rd_done = 1'b1;
    rd_data = 8'h5A;
    step();
    rd_done = 1'b0;
    rd_data = 8'h00;
    chk("nom_fv", flt_valid, 1);
    chk("nom_fd", flt_data, 8'h5A);
    step();
    chk("nom_fv_once", flt_valid, 0);
    step();
    set_col(8'h10, 8'h20, 8'h30);
    step();
    set_col(8'hFF, 8'hFF, 8'hFF);
    cycles(3);
    chk_duty("nom_hold", 0, 0, 0);
    chk("nom_upd0", upd, 0);
    pwm_wrap = 1'b1;
    step();
    pwm_wrap = 1'b0;
    chk_duty("nom_duty", 8'h10, 8'h20, 8'h30);
    chk("nom_upd", upd, 1);
    chk("nom_cnt", sample_cnt, 1);
    step();
    chk("nom_upd_once", upd, 0);
    chk_duty("nom_keep", 8'h10, 8'h20, 8'h30);
    // timeout: rd_done never arrives
    do_reset();
    en = 1'b1;
    wait_req(2 * SP + 4, "to_req");
    en = 1'b0;
    step();
    fv_seen = 0;
    for (int i = 0; i < RT - 1; i++) begin
      pwm_wrap = 1'($urandom_range(0, 1));
      step();
      fv_seen |= flt_valid;
    end
    pwm_wrap = 1'b0;
    chk("to_err_early", err_timeout, 0);
    step();
    fv_seen |= flt_valid;
    chk("to_err", err_timeout, 1);
    chk("to_no_fv", fv_seen, 0);
    chk_duty("to_duty", 0, 0, 0);
    cycles(3);
    chk("to_sticky", err_timeout, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_clr", err_timeout, 0);
    // rd_done on the timeout-limit cycle wins
    do_reset();
    set_col(8'h44, 8'h55, 8'h66);
    en = 1'b1;
    wait_req(2 * SP + 4, "race_req");
    en = 1'b0;
    cycles(RT);
    rd_done = 1'b1;
    rd_data = 8'hC3;
    step();
    rd_done = 1'b0;
    chk("race_fv", flt_valid, 1);
    chk("race_fd", flt_data, 8'hC3);
    chk("race_err", err_timeout, 0);
    cycles(FL + 1);
    pwm_wrap = 1'b1;
    step();
    pwm_wrap = 1'b0;
    chk_duty("race_duty", 8'h44, 8'h55, 8'h66);
    chk("race_cnt", sample_cnt, 1);
    chk("race_err2", err_timeout, 0);
    // commit gating with wrap withheld; ticks land at rd_req+16k
    do_reset();
    set_col(8'h21, 8'h42, 8'h63);
    en = 1'b1;
    wait_req(2 * SP + 4, "ov_req");
    step();
    rd_done = 1'b1;
    rd_data = 8'h99;
    step();
    rd_done = 1'b0;
    for (int n = 3; n <= 44; n++) begin
      step();
      chk("ov_no_req", rd_req, 0);
      chk_duty("ov_hold", 0, 0, 0);
      chk("ov_flag", overrun, n >= SP);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ov_clr", overrun, 0);
    cycles(2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ov_clr_race", overrun, 1);
    pwm_wrap = 1'b1;
    step();
    pwm_wrap = 1'b0;
    chk_duty("ov_duty", 8'h21, 8'h42, 8'h63);
    chk("ov_upd", upd, 1);
    // reset while waiting for wrap with 0x80 committed
    do_reset();
    set_col(8'h80, 8'h80, 8'h80);
    en = 1'b1;
    wait_req(2 * SP + 4, "rw_req");
    en = 1'b0;
    step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    cycles(FL + 1);
    pwm_wrap = 1'b1;
    step();
    pwm_wrap = 1'b0;
    chk_duty("rw_duty", 8'h80, 8'h80, 8'h80);
    set_col(8'h11, 8'h11, 8'h11);
    en = 1'b1;
    wait_req(2 * SP + 4, "rw_req2");
    en = 1'b0;
    step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    cycles(FL + 2);
    chk_duty("rw_hold", 8'h80, 8'h80, 8'h80);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_duty("rw_rst_duty", 0, 0, 0);
    chk("rw_rst_cnt", sample_cnt, 0);
    chk("rw_rst_upd", upd, 0);
    for (int i = 0; i < 3; i++) begin
      pwm_wrap = 1'b1;
      step();
      pwm_wrap = 1'b0;
      chk("rw_no_upd", upd, 0);
      chk("rw_no_req", rd_req, 0);
      step();
    end
    chk_duty("rw_off", 0, 0, 0);
    // en dropped in WAIT_RD: sequence still commits, then silence
    do_reset();
    set_col(8'h0A, 8'h0B, 8'h0C);
    en = 1'b1;
    wait_req(2 * SP + 4, "en_req");
    step();
    en = 1'b0;
    step();
    rd_done = 1'b1;
    rd_data = 8'h3C;
    step();
    rd_done = 1'b0;
    chk("en_fv", flt_valid, 1);
    cycles(FL + 1);
    pwm_wrap = 1'b1;
    step();
    pwm_wrap = 1'b0;
    chk_duty("en_duty", 8'h0A, 8'h0B, 8'h0C);
    chk("en_cnt", sample_cnt, 1);
    fv_seen = 0;
    for (int i = 0; i < 3 * SP; i++) begin
      step();
      fv_seen |= rd_req;
    end
    chk("en_quiet", fv_seen, 0);
    // randomized trials
    for (int t = 0; t < 24; t++) trial(t);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
